// File: rtl/structural_decoder.sv
// structural_decoder
//   2-to-4 one-hot select/strobe decoder. The core is a gate-level network
//   (two inverters, four 3-input ANDs) whose four decode lines are captured
//   by an output register on every rising edge, giving one cycle of latency.
//
//   Ports
//     clk       in   rising-edge clock
//     rst_n     in   asynchronous active-low reset, clears all flops
//     enable    in   decoder enable, active high
//     address0  in   address bit 0 (LSB)
//     address1  in   address bit 1 (MSB)
//     out0..3   out  registered selects, out[{address1,address0}] when enabled
//
//   Optional build macro DECODER_STATUS_EN adds:
//     active      out  registered OR of the decode lines (enable delayed 1 cycle)
//     onehot_err  out  sticky flag, set if the output register is ever seen
//                      holding more than one high bit; cleared only by rst_n
//
//   Parameter GATE_DELAY: delay applied to every core primitive in simulation.

module structural_decoder #(
   parameter int GATE_DELAY = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic enable,
   input  logic address0,
   input  logic address1,
   output logic out0,
   output logic out1,
   output logic out2,
   output logic out3
`ifdef DECODER_STATUS_EN
   ,
   output logic active,
   output logic onehot_err
`endif
);

   wire a0_n;
   wire a1_n;
   wire d0;
   wire d1;
   wire d2;
   wire d3;

   not #(GATE_DELAY) u_inv_a0 (a0_n, address0);
   not #(GATE_DELAY) u_inv_a1 (a1_n, address1);

   and #(GATE_DELAY) u_and_d0 (d0, enable, a1_n, a0_n);
   and #(GATE_DELAY) u_and_d1 (d1, enable, a1_n, address0);
   and #(GATE_DELAY) u_and_d2 (d2, enable, address1, a0_n);
   and #(GATE_DELAY) u_and_d3 (d3, enable, address1, address0);

   logic [3:0] out_d;
   logic [3:0] out_q;

   assign out_d = {d3, d2, d1, d0};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q <= 4'b0000;
      end else begin
         out_q <= out_d;
      end
   end

   assign out0 = out_q[0];
   assign out1 = out_q[1];
   assign out2 = out_q[2];
   assign out3 = out_q[3];

`ifdef DECODER_STATUS_EN
   logic active_d;
   logic active_q;
   logic onehot_err_d;
   logic onehot_err_q;
   logic multi_hot;

   // x & (x-1) clears the lowest set bit; anything left means two or more bits high.
   assign multi_hot    = ((out_q & (out_q - 4'd1)) != 4'b0000);
   assign active_d     = |out_d;
   assign onehot_err_d = onehot_err_q | multi_hot;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q     <= 1'b0;
         onehot_err_q <= 1'b0;
      end else begin
         active_q     <= active_d;
         onehot_err_q <= onehot_err_d;
      end
   end

   assign active     = active_q;
   assign onehot_err = onehot_err_q;
`endif

endmodule

// File: tb/tb_structural_decoder.sv
module tb_structural_decoder;

   logic clk;
   logic rst_n;
   logic enable;
   logic address0;
   logic address1;
   logic out0;
   logic out1;
   logic out2;
   logic out3;
`ifdef DECODER_STATUS_EN
   logic active;
   logic onehot_err;
`endif

   structural_decoder #(.GATE_DELAY(0)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .address0   (address0),
      .address1   (address1),
      .out0       (out0),
      .out1       (out1),
      .out2       (out2),
      .out3       (out3)
`ifdef DECODER_STATUS_EN
      ,
      .active     (active),
      .onehot_err (onehot_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] outv;
      logic       act;
   } exp_t;

   exp_t exp_q[$];
   exp_t cur;
   bit   have;
   int   n_tests;
   int   n_fail;

   // Reference: selected line index is the 2-bit address; disabled means none.
   function automatic exp_t model(input logic en, input int addr);
      exp_t e;
      e.outv = 4'b0000;
      if (en) e.outv[addr] = 1'b1;
      e.act = en;
      return e;
   endfunction

   function automatic logic [3:0] dut_vec();
      return {out3, out2, out1, out0};
   endfunction

   // Apply one input set just after an edge; its response appears after the next edge.
   task automatic drive(input logic en, input int addr);
      @(posedge clk);
      #1;
      enable   = en;
      address1 = addr[1];
      address0 = addr[0];
      exp_q.push_back(model(en, addr));
   endtask

   task automatic check_zero(input string name);
      n_tests++;
      if (dut_vec() !== 4'b0000) begin
         n_fail++;
         $display("FAIL %s: outputs %b, expected 0000", name, dut_vec());
      end
   endtask

   // Monitor: a capture edge with a pending expectation hands it to the
   // following falling edge, where the registered outputs are compared.
   always @(posedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         cur  = exp_q.pop_front();
         have = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (have) begin
         have = 1'b0;
         n_tests++;
         if (dut_vec() !== cur.outv) begin
            n_fail++;
            $display("FAIL out_vec: got %b expected %b", dut_vec(), cur.outv);
         end
         n_tests++;
         if ($countones(dut_vec()) > 1) begin
            n_fail++;
            $display("FAIL onehot: got %b expected at most one bit high", dut_vec());
         end
`ifdef DECODER_STATUS_EN
         n_tests++;
         if (active !== cur.act) begin
            n_fail++;
            $display("FAIL active: got %b expected %b", active, cur.act);
         end
         n_tests++;
         if (onehot_err !== 1'b0) begin
            n_fail++;
            $display("FAIL onehot_err: got %b expected 0", onehot_err);
         end
`endif
      end
   end

   initial begin
      int drain;
      n_tests  = 0;
      n_fail   = 0;
      have     = 1'b0;
      rst_n    = 1'b0;
      enable   = 1'b1;
      address0 = 1'b1;
      address1 = 1'b1;

      #23;
      check_zero("reset_initial");
`ifdef DECODER_STATUS_EN
      n_tests++;
      if (active !== 1'b0 || onehot_err !== 1'b0) begin
         n_fail++;
         $display("FAIL status_reset: active %b onehot_err %b, expected 0 0", active, onehot_err);
      end
`endif
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // enabled sweep
      for (int a = 0; a < 4; a++) drive(1'b1, a);
      // disabled sweep
      for (int a = 0; a < 4; a++) drive(1'b0, a);
      // enable toggle on address 2
      drive(1'b1, 2);
      drive(1'b0, 2);
      drive(1'b1, 2);
      // back-to-back address changes
      drive(1'b1, 0);
      drive(1'b1, 3);
      drive(1'b1, 1);
      drive(1'b1, 2);

      // reset mid-cycle while enabled at address 3
      drive(1'b1, 3);
      drive(1'b1, 3);
      @(posedge clk);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("reset_async");
      @(posedge clk);
      #1;
      check_zero("reset_hold_edge");
      rst_n = 1'b1;
      exp_q.push_back(model(1'b1, 3));

      // randomized traffic, enable biased high
      for (int i = 0; i < 300; i++) begin
         drive(($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)));
      end

      drain = 0;
      while ((exp_q.size() > 0 || have) && drain < 20) begin
         @(posedge clk);
         drain++;
      end
      @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() > 0 || have) begin
         n_fail++;
         $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
